des_ip_input_stage: RTL and testbench
=====================================

// Module: des_ip_input_stage
// PURPOSE
//  Front end of the DES datapath. Collects a 64-bit plaintext/ciphertext block from a narrow beat stream.
//  Applies the DES initial permutation IP and presents L0/R0 halves to the round pipeline over a valid/ready handshake.
//  It is the input-side counterpart of the final permutation (IP^-1) block at the datapath output.
//  Double-buffered: the next block can stream in while the current L0/R0 waits on a stalled consumer.
// PARAMETERS
//  BEAT_W  8  input beat width in bits; legal values 8, 16, 32, 64; NBEATS = 64/BEAT_W
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  abort      in   1       synchronous clear of a partially collected block
//  in_valid   in   1       beat present on in_data
//  in_ready   out  1       stage can accept a beat this cycle
//  in_data    in   BEAT_W  beat; in_data MSB = lowest block bit index (block bit 0 = MSB of first beat)
//  out_valid  out  1       out_l/out_r hold a permuted block
//  out_ready  in   1       consumer accepts the block this cycle
//  out_l      out  32      L0 = IP(block)[0:31], bit 0 = MSB
//  out_r      out  32      R0 = IP(block)[32:63], bit 0 = MSB
// BEHAVIOUR
//  - Reset (async, rst_n=0): beat_cnt=0, collect buffer cleared, out_valid=0, out_l=out_r=0, in_ready=1 after release.
//  - Beat accepted when in_valid&&in_ready; it is shifted into the collect buffer; beat_cnt increments mod NBEATS.
//  - IP: out[8r+c] = in[8*(7-c) + (r<4 ? 2r+1 : 2(r-4))], r,c in 0..7, indices MSB-first [0:63].
//  - Accepting the last beat (beat_cnt==NBEATS-1) when the output register is free or draining:
//    the IP of the completed block loads out_l/out_r; out_valid=1 on the next cycle (latency 1 clk from last beat).
//  - Output register is free when out_valid=0, and draining when out_valid&&out_ready.
//  - If the last beat arrives while out_valid=1 and out_ready=0, the block stays in the collect buffer (FULL).
//    In FULL, in_ready=0; it transfers to the output register in the cycle out_ready=1. in_ready returns to 1 the next cycle.
//  - in_ready = !FULL; it is a registered, not combinational, function of out_ready.
//  - out_l/out_r/out_valid are stable while out_valid&&!out_ready. They are not modified until the handshake completes.
//  - Same-cycle handshake with a new load: the old block is consumed and the new block is loaded, so out_valid stays 1.
//  - Collector states: COLLECT (beat_cnt 0..NBEATS-1) and FULL. Output register states: EMPTY and HOLD.
//  - abort: beat_cnt=0 and FULL cleared (the held block is discarded); output register and out_valid untouched.
//    abort has priority over a same-cycle beat, which is dropped.
//  - BEAT_W=64: every beat completes a block; beat_cnt is constant 0.
//  - rst_n asserted mid-block or mid-hold: all state discarded immediately, no partial output.
// STRUCTURE
//  - des_pkg: DES_BLOCK_W=64, DES_HALF_W=32, IP table as localparam int array [0:63], block/half typedefs.
//    The IP^-1 table lives there too.
//  - Sub-module des_ip_perm: purely combinational 64-bit IP mapping driven from the des_pkg table.
//    It sits between the collect buffer and the output register.
//  - Top holds beat_cnt, collect buffer, FULL flag, output register, handshake logic.
// TESTING
//  - Stream 01 23 45 67 89 AB CD EF (BEAT_W=8), out_ready=1
//    -> out_l=CC00CCFF, out_r=F0AAF0AA, out_valid 1 clk after 8th beat.
//  - Block 8000000000000000 -> out_l=00000000, out_r=01000000; block FFFFFFFFFFFFFFFF -> both halves FFFFFFFF.
//  - out_ready=0, send two blocks back-to-back -> first held stable, in_ready=0 after 16th beat.
//    Raise out_ready -> first then second delivered in order, none lost.
//  - Continuous in_valid=1, out_ready=1 -> one block per 8 clks, out_valid pulses each 8th cycle, in_ready never drops.
//  - abort after 3 beats, then send 0123456789ABCDEF -> only that block emerges, with correct L0/R0.
//  - rst_n low for 1 clk mid-block and while HOLD -> out_valid=0, outputs 0, next full block correct.
//  - Repeat the first test with BEAT_W=16 (0123,4567,89AB,CDEF) and BEAT_W=64 -> identical L0/R0.

Source files
------------

// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
//   Shared DES datapath definitions: block and half-block widths, their
//   typedefs, the collector/output-register state encodings, and the
//   initial permutation (IP) and final permutation (IP^-1) tables.
//
//   Both tables use MSB-first indexing. Entry i holds the source bit index
//   for output bit i, with bit 0 being the MSB of the 64-bit block.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package des_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_HALF_W  = 32;

  typedef logic [DES_BLOCK_W-1:0] des_block_t;
  typedef logic [DES_HALF_W-1:0]  des_half_t;

  // Collector holds either a partial block (COLLECT) or a completed block
  // that is waiting for the output register to free up (FULL).
  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } collect_state_e;

  // Output register either has no block (EMPTY) or presents one (HOLD).
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } out_state_e;

  // Initial permutation, zero-based, MSB-first: out[i] = in[DES_IP[i]].
  localparam int DES_IP [0:DES_BLOCK_W-1] = '{
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7,
    56, 48, 40, 32, 24, 16,  8,  0,
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6
  };

  // Final permutation (inverse of DES_IP), same indexing convention.
  localparam int DES_IP_INV [0:DES_BLOCK_W-1] = '{
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25,
    32,  0, 40,  8, 48, 16, 56, 24
  };

endpackage : des_pkg

// File: rtl/des_ip_perm.sv
// -----------------------------------------------------------------------------
// des_ip_perm
//   Purely combinational DES initial permutation driven from des_pkg::DES_IP.
//   Block bit 0 is the MSB of the vector, so table index i maps to vector
//   bit (DES_BLOCK_W-1-i).
//
// Ports
//   blk_in   in   64  block before IP
//   blk_out  out  64  IP(blk_in)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module des_ip_perm
  import des_pkg::*;
(
  input  logic [DES_BLOCK_W-1:0] blk_in,
  output logic [DES_BLOCK_W-1:0] blk_out
);

  always_comb begin
    // NOTE: default assignment first so every path of this block drives
    // blk_out fully and no latch is inferred.
    blk_out = '0;
    for (int i = 0; i < DES_BLOCK_W; i++) begin
      blk_out[DES_BLOCK_W-1-i] = blk_in[DES_BLOCK_W-1-DES_IP[i]];
    end
  end

endmodule : des_ip_perm

// File: rtl/des_ip_input_stage.sv
// -----------------------------------------------------------------------------
// des_ip_input_stage
//   Front end of the DES datapath. Collects a 64-bit block from a stream of
//   BEAT_W-bit beats (first beat = most significant), applies the initial
//   permutation and presents L0/R0 over a valid/ready handshake.
//
//   Double-buffered: the collect buffer keeps filling while the output
//   register holds a block for a stalled consumer. A block completed while
//   the output is stalled parks in the collect buffer (FULL) and moves to
//   the output register in the cycle the consumer accepts the old block.
//
// Parameters
//   BEAT_W     beat width in bits: 8, 16, 32 or 64
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   abort      in   1        synchronous discard of partial / parked block
//   in_valid   in   1        beat present on in_data
//   in_ready   out  1        stage accepts a beat this cycle (registered)
//   in_data    in   BEAT_W   beat, MSB = lowest block bit index
//   out_valid  out  1        out_l/out_r hold a permuted block
//   out_ready  in   1        consumer takes the block this cycle
//   out_l      out  32       L0 = IP(block)[0:31]
//   out_r      out  32       R0 = IP(block)[32:63]
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module des_ip_input_stage
  import des_pkg::*;
#(
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DES_HALF_W-1:0] out_l,
  output logic [DES_HALF_W-1:0] out_r
);

  localparam int NBEATS = DES_BLOCK_W / BEAT_W;
  // A single-beat configuration still needs a 1-bit counter to keep the
  // declarations legal; it simply never leaves zero.
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  logic [CNT_W-1:0] beat_cnt;
  des_block_t       collect_q;
  des_block_t       block_next;
  des_block_t       perm_in;
  des_block_t       perm_out;
  collect_state_e   coll_state;
  out_state_e       out_state;

  logic beat_acc;
  logic last_beat;
  logic out_free;
  logic held_xfer;
  logic direct_load;

  // ---------------------------------------------------------------------------
  // Collect buffer shift path: the newest beat enters at the LSB end so the
  // first beat ends up in the MSBs (block bit 0).
  // ---------------------------------------------------------------------------
  if (NBEATS == 1) begin : g_single_beat
    assign block_next = in_data;
  end else begin : g_multi_beat
    assign block_next = {collect_q[DES_BLOCK_W-BEAT_W-1:0], in_data};
  end

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // in_ready depends only on registered state, never on out_ready directly.
  assign in_ready  = (coll_state == COLLECT);
  assign out_valid = (out_state == HOLD);

  assign beat_acc    = in_valid && in_ready && !abort;
  assign last_beat   = beat_acc && (beat_cnt == LAST_BEAT);
  // Output register can take a new block if empty or being drained now.
  assign out_free    = (out_state == EMPTY) || out_ready;
  // Parked block moves out when the consumer takes the current one; an
  // abort in the same cycle discards it instead.
  assign held_xfer   = (coll_state == FULL) && out_ready && !abort;
  assign direct_load = last_beat && out_free;

  // While FULL the parked block is the permutation source; otherwise the
  // block being completed by the current beat is.
  assign perm_in = (coll_state == FULL) ? collect_q : block_next;

  des_ip_perm u_ip_perm (
    .blk_in  (perm_in),
    .blk_out (perm_out)
  );

  // ---------------------------------------------------------------------------
  // Collector: beat counter, collect buffer, COLLECT/FULL state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt   <= '0;
      // NOTE: the collect buffer is a plain register (not a memory), so it
      // is reset along with the control state and never leaks old data.
      collect_q  <= '0;
      coll_state <= COLLECT;
    end else if (abort) begin
      beat_cnt   <= '0;
      coll_state <= COLLECT;
    end else if (held_xfer) begin
      coll_state <= COLLECT;
    end else if (beat_acc) begin
      collect_q <= block_next;
      if (last_beat) begin
        beat_cnt <= '0;
        if (!out_free) begin
          coll_state <= FULL;
        end
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: EMPTY/HOLD state and L0/R0 halves
  // ---------------------------------------------------------------------------
  // A load in the same cycle as a handshake replaces the consumed block, so
  // out_valid stays high with no bubble. Nothing changes while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state <= EMPTY;
      out_l     <= '0;
      out_r     <= '0;
    end else if (direct_load || held_xfer) begin
      out_state <= HOLD;
      out_l     <= perm_out[DES_BLOCK_W-1:DES_HALF_W];
      out_r     <= perm_out[DES_HALF_W-1:0];
    end else if (out_valid && out_ready) begin
      out_state <= EMPTY;
    end
  end

endmodule : des_ip_input_stage

// File: tb/tb_des_ip_input_stage.sv
// -----------------------------------------------------------------------------
// tb_des_ip_input_stage
//   Directed bench for des_ip_input_stage. The main instance uses 8-bit
//   beats; two side instances (16- and 64-bit beats) confirm the beat width
//   does not change L0/R0. Expected values are hand-computed IP results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_des_ip_input_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_l;
  logic [31:0] out_r;

  logic        in16_valid, in16_ready, out16_valid;
  logic [15:0] in16_data;
  logic [31:0] out16_l, out16_r;

  logic        in64_valid, in64_ready, out64_valid;
  logic [63:0] in64_data;
  logic [31:0] out64_l, out64_r;

  logic        side_abort;
  logic        side_out_ready;

  des_ip_input_stage #(.BEAT_W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_l     (out_l),
    .out_r     (out_r)
  );

  des_ip_input_stage #(.BEAT_W(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (side_abort),
    .in_valid  (in16_valid),
    .in_ready  (in16_ready),
    .in_data   (in16_data),
    .out_valid (out16_valid),
    .out_ready (side_out_ready),
    .out_l     (out16_l),
    .out_r     (out16_r)
  );

  des_ip_input_stage #(.BEAT_W(64)) u_dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (side_abort),
    .in_valid  (in64_valid),
    .in_ready  (in64_ready),
    .in_data   (in64_data),
    .out_valid (out64_valid),
    .out_ready (side_out_ready),
    .out_l     (out64_l),
    .out_r     (out64_r)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [63:0] blk;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  vec_t vecs [0:5];

  localparam logic [63:0] BLK_A   = 64'h0123456789ABCDEF;
  localparam logic [31:0] BLK_A_L = 32'hCC00CCFF;
  localparam logic [31:0] BLK_A_R = 32'hF0AAF0AA;
  localparam logic [63:0] BLK_B   = 64'h8000000000000000;
  localparam logic [31:0] BLK_B_L = 32'h00000000;
  localparam logic [31:0] BLK_B_R = 32'h01000000;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; all driving and sampling happens 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream one block as eight bytes, waiting (bounded) for in_ready.
  task automatic send8(input logic [63:0] blk);
    for (int b = 0; b < 8; b++) begin
      int w;
      in_data  = blk[63-8*b -: 8];
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 64) begin
        step();
        w++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL send8_ready_timeout: got in_ready=0 expected 1");
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"ip_0123", BLK_A, BLK_A_L, BLK_A_R};
    vecs[1] = '{"ip_msb",  BLK_B, BLK_B_L, BLK_B_R};
    vecs[2] = '{"ip_ones", 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[3] = '{"ip_zero", 64'h0000000000000000, 32'h00000000, 32'h00000000};
    vecs[4] = '{"ip_lsb",  64'h0000000000000001, 32'h00000080, 32'h00000000};
    vecs[5] = '{"ip_bit31",64'h0000000100000000, 32'h00000008, 32'h00000000};

    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in16_valid = 1'b0; in16_data = '0; in64_valid = 1'b0; in64_data = '0;
    side_abort = 1'b0; side_out_ready = 1'b1;

    // ---------------- reset state ----------------
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_l", out_l, 0);
    check("rst_out_r", out_r, 0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", in_ready, 1);

    // ---------------- table: one block each, latency 1 clk ----------------
    for (int v = 0; v < 6; v++) begin
      send8(vecs[v].blk);
      check({vecs[v].name, "_valid"}, out_valid, 1);
      check({vecs[v].name, "_l"}, out_l, vecs[v].exp_l);
      check({vecs[v].name, "_r"}, out_r, vecs[v].exp_r);
      step();
      check({vecs[v].name, "_drain"}, out_valid, 0);
    end

    // ---------------- back-to-back under stall ----------------
    out_ready = 1'b0;
    send8(BLK_A);
    send8(BLK_B);
    check("b2b_in_ready_full", in_ready, 0);
    repeat (3) step();
    check("b2b_hold_valid", out_valid, 1);
    check("b2b_hold_l", out_l, BLK_A_L);
    check("b2b_hold_r", out_r, BLK_A_R);
    check("b2b_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("b2b_first_l", out_l, BLK_A_L);
    step();
    check("b2b_second_valid", out_valid, 1);
    check("b2b_second_l", out_l, BLK_B_L);
    check("b2b_second_r", out_r, BLK_B_R);
    check("b2b_in_ready_back", in_ready, 1);
    step();
    check("b2b_drained", out_valid, 0);

    // ---------------- continuous streaming ----------------
    begin
      int pulses = 0;
      int drops  = 0;
      int bad    = 0;
      for (int cyc = 0; cyc < 24; cyc++) begin
        in_valid = 1'b1;
        in_data  = BLK_A[63-8*(cyc%8) -: 8];
        step();
        if (!in_ready) drops++;
        if (out_valid) begin
          pulses++;
          if (out_l !== BLK_A_L || out_r !== BLK_A_R) bad++;
        end
        if (out_valid !== ((cyc % 8) == 7)) bad++;
      end
      in_valid = 1'b0;
      step();
      check("stream_pulses", pulses, 3);
      check("stream_ready_drops", drops, 0);
      check("stream_bad_cycles", bad, 0);
    end

    // ---------------- abort after 3 beats ----------------
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
      step();
    end
    abort = 1'b1; in_data = 8'h55;  // beat dropped by abort
    step();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_no_valid", out_valid, 0);
    send8(BLK_A);
    check("abort_valid", out_valid, 1);
    check("abort_l", out_l, BLK_A_L);
    check("abort_r", out_r, BLK_A_R);
    step();

    // ---------------- abort while FULL discards the parked block ----------------
    out_ready = 1'b0;
    send8(BLK_A);
    send8(BLK_B);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_full_in_ready", in_ready, 1);
    check("abort_full_hold_l", out_l, BLK_A_L);
    out_ready = 1'b1;
    step();
    step();
    check("abort_full_discard", out_valid, 0);

    // ---------------- reset mid-block ----------------
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    send8(BLK_A);
    check("rst_mid_next_l", out_l, BLK_A_L);
    check("rst_mid_next_r", out_r, BLK_A_R);
    step();

    // ---------------- reset while HOLD ----------------
    out_ready = 1'b0;
    send8(64'hFFFFFFFFFFFFFFFF);
    check("rst_hold_pre", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_l", out_l, 0);
    check("rst_hold_r", out_r, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    send8(BLK_B);
    check("rst_hold_next_l", out_l, BLK_B_L);
    check("rst_hold_next_r", out_r, BLK_B_R);
    step();

    // ---------------- 16-bit beats ----------------
    for (int b = 0; b < 4; b++) begin
      in16_valid = 1'b1;
      in16_data  = BLK_A[63-16*b -: 16];
      step();
    end
    in16_valid = 1'b0;
    check("w16_valid", out16_valid, 1);
    check("w16_l", out16_l, BLK_A_L);
    check("w16_r", out16_r, BLK_A_R);

    // ---------------- 64-bit beats ----------------
    in64_valid = 1'b1;
    in64_data  = BLK_A;
    step();
    in64_valid = 1'b0;
    check("w64_valid", out64_valid, 1);
    check("w64_l", out64_l, BLK_A_L);
    check("w64_r", out64_r, BLK_A_R);
    check("w64_in_ready", in64_ready, 1);
    step();
    check("w16_ready", in16_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_des_ip_input_stage
